proc_port_driver: RTL

Processor-side initiator for one cache core's `p_addr/p_data/p_func/req/ready` port: it plays the CPU role that each cache core serves. Commands from a bench or scripted source are queued in a 4-entry FIFO and issued one at a time. Each command is held on the port until `ready`, with read data captured and returned as a response. One instance sits in front of each cache core in the dual-core MSI system; it also gives coherence tests a timeout monitor and per-operation latency.

---
 rtl/proc_port_driver_if.sv | 11 +
 rtl/proc_port_driver.sv | 125 ++++++++++++
 2 files changed

// File: rtl/proc_port_driver_if.sv
// Processor-side cache port handshake: address, function and req/ready.
// The bidirectional data bus stays a plain inout on the driver so its tristate resolves at the module boundary.
interface proc_port_driver_if;
  logic [7:0] p_addr;
  logic       p_func;
  logic       req;
  logic       ready;

  modport master (output p_addr, output p_func, output req, input ready);
  modport slave  (input p_addr, input p_func, input req, output ready);
endinterface

// File: rtl/proc_port_driver.sv
// CPU-role initiator for one cache core: queues load/store commands in a small FIFO,
// issues them one at a time on the req/ready port, and reports data, latency and timeouts.
module proc_port_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  input  logic                      cmd_write,
  input  logic [7:0]                cmd_addr,
  input  logic [7:0]                cmd_wdata,
  output logic                      cmd_ready,
  proc_port_driver_if.master        cache,
  inout  wire  [7:0]                p_data,
  output logic                      rsp_valid,
  output logic [7:0]                rsp_data,
  output logic                      rsp_err,
  output logic [7:0]                rsp_latency,
  output logic                      busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RDY, RELEASE} state_t;

  cmd_t        mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, push, pop;
  state_t      state, next_state;
  cmd_t        op;
  logic [7:0]  wait_cnt;
  logic        req_q, req_d, drive_q, drive_d;
  logic        done, abort;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == IDLE) && !empty && !cache.ready;
  assign busy      = !empty || (state != IDLE);

  assign done  = (state == WAIT_RDY) && cache.ready;
  assign abort = (state == WAIT_RDY) && !cache.ready && (wait_cnt == 8'(TIMEOUT));

  assign cache.req    = req_q;
  assign cache.p_addr = op.addr;
  assign cache.p_func = op.write;
  assign p_data       = drive_q ? op.wdata : 8'bz;

  // NOTE: queue storage carries no reset; the pointers alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (!empty && !cache.ready) next_state = ISSUE;
      ISSUE:    next_state = WAIT_RDY;
      WAIT_RDY: if (done || abort) next_state = RELEASE;
      RELEASE:  if (!cache.ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Port controls are registered from the next state so req rises one edge after ISSUE.
  always_comb begin
    req_d   = (next_state == WAIT_RDY);
    drive_d = req_d && op.write;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op          <= '0;
      req_q       <= 1'b0;
      drive_q     <= 1'b0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_latency <= '0;
    end else begin
      req_q     <= req_d;
      drive_q   <= drive_d;
      rsp_valid <= done || abort;
      if (pop) op <= mem[rptr[AW-1:0]];
      if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT_RDY && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
      if (done) begin
        rsp_data    <= op.write ? 8'h00 : p_data;
        rsp_err     <= 1'b0;
        rsp_latency <= (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
      end else if (abort) begin
        rsp_data    <= 8'h00;
        rsp_err     <= 1'b1;
        rsp_latency <= 8'hFF;
      end
    end
  end

endmodule
